// File: rtl/controle_cronometro.sv
`default_nettype none
// ============================================================================
//  Module   : controle_cronometro
//  Purpose  : Stopwatch sequencer between the 100 Hz divider output and the
//             BCD time-counter datapath. Conditions two raw push-buttons into
//             single-cycle press events, runs the PARADO/CONTANDO/VOLTA/PAUSADO
//             state machine, turns 100 Hz tick rises into one-cycle count
//             enables and issues counter clear and display freeze.
//  Ports    : clk_in          in   50 MHz system clock
//             rst             in   asynchronous reset, active low
//             btn_start_n     in   raw start/stop button, active low, async
//             btn_lap_n       in   raw lap/reset button, active low, async
//             tick_in         in   100 Hz square wave from the divider, async
//             count_en        out  one-cycle pulse: advance counters by 10 ms
//             count_clr       out  one-cycle pulse: clear counters to zero
//             display_freeze  out  level: display holds latched value (lap)
//             running         out  level: 1 in CONTANDO or VOLTA
//             state           out  FSM state code
//  Options  : define CTRL_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES debounce
//             filter (DB_W-bit counter) on each button. Without it the
//             synchronised level is used directly and both parameters are
//             only range-checked.
//  Revision : 1.0 - initial release
// ============================================================================
module controle_cronometro #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_start_n,
    input  logic       btn_lap_n,
    input  logic       tick_in,
    output logic       count_en,
    output logic       count_clr,
    output logic       display_freeze,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        VOLTA    = 2'b11
    } state_t;

    // Reject parameter sets where the debounce counter cannot reach its limit.
    if ((DB_W < 1) || (DB_W > 30) || (DEBOUNCE_CYCLES < 1) ||
        ((1 << DB_W) <= DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("controle_cronometro: DB_W too small for DEBOUNCE_CYCLES");
    end

    // ------------------------------------------------------------------------
    // Start-up qualifier: r_v2 is high once the button synchronisers hold a
    // real sample rather than their reset value. A button is only armed after
    // it has genuinely been seen released, so a button held through reset
    // does not produce a press when reset is released.
    // ------------------------------------------------------------------------
    logic r_v1;
    logic r_v2;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= 1'b1;
            r_v2 <= r_v1;
        end
    end

    // ------------------------------------------------------------------------
    // Button conditioning: bit 0 = start, bit 1 = lap.
    // ------------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_lap_n, btn_start_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic r_s1;
        logic r_s2;
        logic r_s3;     // history of the accepted level
        logic r_armed;
        logic w_level;  // accepted (conditioned) level, 1 = released

`ifdef CTRL_DEBOUNCE_EN
        localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

        logic [DB_W-1:0] r_cnt;
        logic            r_acc;

        // The count runs only while the synchronised level differs from the
        // accepted one; any return to the accepted level restarts it.
        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                r_cnt <= '0;
                r_acc <= 1'b1;
            end else if (r_s2 == r_acc) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_cnt <= '0;
                r_acc <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_level = r_acc;
`else
        assign w_level = r_s2;
`endif

        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_s3    <= 1'b1;
                r_armed <= 1'b0;
            end else begin
                r_s1    <= w_btn_raw[gi];
                r_s2    <= r_s1;
                r_s3    <= w_level;
                r_armed <= r_armed | (r_v2 & r_s2 & w_level);
            end
        end

        // Released -> pressed transition of the accepted level.
        assign w_press[gi] = r_armed & r_s3 & ~w_level;
    end

    logic w_start;
    logic w_lap;

    assign w_start = w_press[0];
    assign w_lap   = w_press[1];

    // ------------------------------------------------------------------------
    // Tick conditioning
    // ------------------------------------------------------------------------
    logic r_t1;
    logic r_t2;
    logic r_t3;
    logic w_tick_rise;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_t1 <= 1'b0;
            r_t2 <= 1'b0;
            r_t3 <= 1'b0;
        end else begin
            r_t1 <= tick_in;
            r_t2 <= r_t1;
            r_t3 <= r_t2;
        end
    end

    assign w_tick_rise = r_t2 & ~r_t3;

    // ------------------------------------------------------------------------
    // Sequencer. Start has priority over lap. count_en looks at the state
    // before this edge's update, so a tick coinciding with leaving a counting
    // state is still counted.
    // ------------------------------------------------------------------------
    state_t r_state;
    logic   r_count_en;
    logic   r_count_clr;
    logic   r_freeze;
    logic   r_running;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state     <= PARADO;
            r_count_en  <= 1'b0;
            r_count_clr <= 1'b0;
            r_freeze    <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_count_en  <= w_tick_rise & ((r_state == CONTANDO) | (r_state == VOLTA));
            r_count_clr <= 1'b0;
            case (r_state)
                PARADO: begin
                    if (w_start) begin
                        r_state   <= CONTANDO;
                        r_running <= 1'b1;
                    end else if (w_lap) begin
                        r_count_clr <= 1'b1;
                    end
                end
                CONTANDO: begin
                    if (w_start) begin
                        r_state   <= PAUSADO;
                        r_running <= 1'b0;
                    end else if (w_lap) begin
                        r_state  <= VOLTA;
                        r_freeze <= 1'b1;
                    end
                end
                VOLTA: begin
                    if (w_start) begin
                        r_state   <= PAUSADO;
                        r_freeze  <= 1'b0;
                        r_running <= 1'b0;
                    end else if (w_lap) begin
                        r_state  <= CONTANDO;
                        r_freeze <= 1'b0;
                    end
                end
                PAUSADO: begin
                    if (w_start) begin
                        r_state   <= CONTANDO;
                        r_running <= 1'b1;
                    end else if (w_lap) begin
                        r_state     <= PARADO;
                        r_count_clr <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= PARADO;
                    r_freeze  <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign count_en       = r_count_en;
    assign count_clr      = r_count_clr;
    assign display_freeze = r_freeze;
    assign running        = r_running;
    assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_controle_cronometro.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controle_cronometro
//  Purpose  : Directed self-checking bench for controle_cronometro
//             (DEBOUNCE_CYCLES=4, DB_W=3, tick period 40 clk_in cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controle_cronometro;

`ifdef CTRL_DEBOUNCE_EN
    localparam int         LAT            = 7;      // press -> state visible
    localparam int         EXP_BOUNCE_CHG = 1;
    localparam logic [1:0] EXP_BOUNCE_MID = 2'b10;
    localparam logic [1:0] EXP_BOUNCE_END = 2'b01;
`else
    localparam int         LAT            = 3;
    localparam int         EXP_BOUNCE_CHG = 6;
    localparam logic [1:0] EXP_BOUNCE_MID = 2'b01;
    localparam logic [1:0] EXP_BOUNCE_END = 2'b10;
`endif
    localparam int RELW = LAT + 6;

    logic       clk_in;
    logic       rst;
    logic       btn_start_n;
    logic       btn_lap_n;
    logic       tick_in;
    logic       count_en;
    logic       count_clr;
    logic       display_freeze;
    logic       running;
    logic [1:0] state;

    controle_cronometro #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (3)
    ) u_dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .btn_start_n    (btn_start_n),
        .btn_lap_n      (btn_lap_n),
        .tick_in        (tick_in),
        .count_en       (count_en),
        .count_clr      (count_clr),
        .display_freeze (display_freeze),
        .running        (running),
        .state          (state)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Activity monitors updated every step.
    int         en_cnt     = 0;
    int         en_wide    = 0;
    int         en_bad_lat = 0;
    int         clr_cnt    = 0;
    int         both_err   = 0;
    int         st_chg     = 0;
    int         since_rise = 1000;
    int         tick_ph    = 0;
    bit         tick_on    = 1'b0;
    bit         tick_man   = 1'b0;
    logic       prev_en    = 1'b0;
    logic [1:0] prev_state = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive the tick, cross the edge, sample 1 ns later.
    task automatic step();
        logic nt;
        nt = tick_on ? (tick_ph < 20) : tick_man;
        if (nt && !tick_in) since_rise = 0;
        tick_in = nt;
        @(posedge clk_in);
        #1;
        tick_ph = (tick_ph + 1) % 40;
        if (since_rise < 1000) since_rise++;
        if (count_en) begin
            en_cnt++;
            if (since_rise != 3) en_bad_lat++;
            if (prev_en) en_wide++;
        end
        prev_en = count_en;
        if (count_clr) clr_cnt++;
        if (count_en && count_clr) both_err++;
        if (state != prev_state) st_chg++;
        prev_state = state;
    endtask

    task automatic press(input bit s, input bit l);
        btn_start_n = ~s;
        btn_lap_n   = ~l;
        repeat (LAT) step();
    endtask

    task automatic release_btns();
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        repeat (RELW) step();
    endtask

    initial begin
        rst         = 1'b0;
        btn_start_n = 1'b0;
        btn_lap_n   = 1'b0;
        tick_in     = 1'b0;

        // ---------------- reset with both buttons held ----------------
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({count_en, count_clr, display_freeze, running}), 32'd0);
        rst     = 1'b1;
        st_chg  = 0;
        clr_cnt = 0;
        repeat (20) step();
        check("held_state", 32'(state), 32'd0);
        check("held_no_event", 32'(st_chg + clr_cnt), 32'd0);
        release_btns();
        check("release_no_event", 32'(st_chg + clr_cnt), 32'd0);

        // ---------------- run ----------------
        tick_ph = 20;
        tick_on = 1'b1;
        btn_start_n = 1'b0;
        repeat (LAT - 1) step();
        check("start_not_yet", 32'(state), 32'd0);
        step();
        check("start_state", 32'(state), 32'd1);
        check("start_running", 32'(running), 32'd1);
        release_btns();
        en_cnt = 0; en_wide = 0; en_bad_lat = 0;
        repeat (400) step();
        check("run_en_count", 32'(en_cnt), 32'd10);
        check("run_en_width", 32'(en_wide), 32'd0);
        check("run_en_latency", 32'(en_bad_lat), 32'd0);

        // ---------------- lap ----------------
        press(1'b0, 1'b1);
        check("lap_state", 32'(state), 32'd3);
        check("lap_freeze", 32'(display_freeze), 32'd1);
        check("lap_running", 32'(running), 32'd1);
        release_btns();
        en_cnt = 0;
        repeat (80) step();
        check("lap_en_count", 32'(en_cnt), 32'd2);
        press(1'b0, 1'b1);
        check("unlap_state", 32'(state), 32'd1);
        check("unlap_freeze", 32'(display_freeze), 32'd0);
        release_btns();

        // ---------------- stop / clear ----------------
        press(1'b1, 1'b0);
        check("pause_state", 32'(state), 32'd2);
        check("pause_running", 32'(running), 32'd0);
        release_btns();
        en_cnt = 0;
        repeat (80) step();
        check("pause_en_count", 32'(en_cnt), 32'd0);
        clr_cnt = 0;
        press(1'b0, 1'b1);
        check("clear_state", 32'(state), 32'd0);
        check("clear_pulse", 32'(count_clr), 32'd1);
        step();
        check("clear_pulse_end", 32'(count_clr), 32'd0);
        release_btns();
        check("clear_count", 32'(clr_cnt), 32'd1);
        press(1'b0, 1'b1);
        check("idle_clear_state", 32'(state), 32'd0);
        check("idle_clear_pulse", 32'(count_clr), 32'd1);
        release_btns();
        check("idle_clear_count", 32'(clr_cnt), 32'd2);

        // ---------------- simultaneous events ----------------
        press(1'b1, 1'b0);
        check("resume_state", 32'(state), 32'd1);
        release_btns();
        tick_on  = 1'b0;
        tick_man = 1'b0;
        repeat (5) step();
        btn_start_n = 1'b0;
        btn_lap_n   = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (i == LAT - 3) tick_man = 1'b1;
            step();
        end
        check("both_state", 32'(state), 32'd2);
        check("both_freeze", 32'(display_freeze), 32'd0);
        check("edge_tick_counted", 32'(count_en), 32'd1);
        step();
        check("edge_tick_single", 32'(count_en), 32'd0);
        tick_man = 1'b0;
        release_btns();

        // ---------------- bouncing start button ----------------
        st_chg = 0;
        for (int i = 0; i < 20; i++) begin
            btn_start_n = ((i / 2) % 2 == 1);
            step();
        end
        btn_start_n = 1'b0;
        repeat (LAT - 1) step();
        check("bounce_before", 32'(state), 32'(EXP_BOUNCE_MID));
        step();
        check("bounce_after", 32'(state), 32'(EXP_BOUNCE_END));
        repeat (5) step();
        check("bounce_events", 32'(st_chg), 32'(EXP_BOUNCE_CHG));
        release_btns();

        // ---------------- reset mid-operation ----------------
        if (EXP_BOUNCE_END == 2'b10) begin
            press(1'b1, 1'b0);
            release_btns();
        end
        press(1'b0, 1'b1);
        check("pre_rst_lap", 32'(state), 32'd3);
        release_btns();
        tick_on = 1'b1;
        repeat (7) step();
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_outs",
              32'({count_en, count_clr, display_freeze, running, state}), 32'd0);
        @(posedge clk_in);
        #1;
        rst    = 1'b1;
        en_cnt = 0;
        st_chg = 0;
        repeat (50) step();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_no_count", 32'(en_cnt), 32'd0);

        // ---------------- global invariants ----------------
        check("en_clr_exclusive", 32'(both_err), 32'd0);
        check("en_width_total", 32'(en_wide), 32'd0);
        check("en_latency_total", 32'(en_bad_lat), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
